board_id_ctl: RTL and testbench
===============================

Name: board_id_ctl

Overview:
- Clocked controller that negotiates a unique board ID (1, 2, or spectator 3) among up to three linked boards.
- Sits between the game-start logic (which requests the lock) and the inter-board link (which carries claim messages and external occupancy flags).
- Listens for existing claims, selects the lowest free ID, announces it over a valid/ready handshake, then holds it.
- Detects collisions and resolves them with pseudo-random backoff and retry.

Parameters:
- LISTEN_CYCLES, 1000, cycles spent sampling external claims before selecting an ID (>=2).
- BACKOFF_BITS, 8, width of the LFSR-derived backoff count; backoff = LFSR[BACKOFF_BITS-1:0] + 1 cycles.
- MAX_RETRY, 3, collisions tolerated before falling back to spectator ID 3.
- LFSR_SEED, 16'hACE1, non-zero seed of the 16-bit Fibonacci LFSR (taps 16,14,13,11); must differ per board.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- lock_req, input, 1, one-cycle pulse: start negotiation.
- ext_id1_claim, input, 1, async level: another board holds ID 1.
- ext_id2_claim, input, 1, async level: another board holds ID 2.
- claim_ready, input, 1, link accepts the current claim message.
- claim_valid, output, 1, claim message pending.
- claim_id, output, 2, ID being announced (1, 2 or 3).
- board_id, output, 8, assigned ID, zero-extended; 0 until locked.
- id_locked, output, 1, board_id is final and valid.
- busy, output, 1, negotiation in progress (any state except IDLE and HOLD).
- collision, output, 1, one-cycle pulse on each detected collision.

Behaviour:
- Reset: all outputs are 0, state IDLE, retry count 0, LFSR = LFSR_SEED.
- Synchronisation: ext_id*_claim pass through 2-FF synchronisers. All decisions use the synchronised values (2-cycle latency).
- LFSR: advances every cycle in every state and never reaches 0.
- IDLE:
  - lock_req=1 -> LISTEN. Clear the occupancy sticky bits occ1/occ2, load the listen counter with LISTEN_CYCLES-1, assert busy.
  - lock_req is ignored in every state other than IDLE.
- LISTEN:
  - occ1 |= sync1 and occ2 |= sync2 each cycle.
  - Counter decrements; at 0 -> SELECT.
- SELECT (1 cycle):
  - If retry count >= MAX_RETRY, select 3.
  - Otherwise: !occ1 -> 1; else !occ2 -> 2; else 3.
  - Then -> ANNOUNCE.
- ANNOUNCE:
  - claim_valid=1 with claim_id stable until claim_ready is sampled high. That cycle is the handshake.
  - On handshake -> HOLD. Next cycle: board_id={6'b0,claim_id}, id_locked=1, busy=0, claim_valid=0.
  - If the synchronised claim for the selected ID (1 or 2) rises while waiting, withdraw: claim_valid=0, pulse collision, retry++ -> BACKOFF.
  - ID 3 never collides.
- HOLD:
  - Holds until reset; lock_req is ignored.
  - If the synchronised external claim matching the held ID (1 or 2) is high for 2 consecutive cycles: pulse collision, clear board_id/id_locked, retry++ -> BACKOFF.
- BACKOFF:
  - Load the counter with LFSR[BACKOFF_BITS-1:0]+1, count to 0, then -> LISTEN with fresh occ bits.
  - busy=1.
- Retry count saturates at MAX_RETRY.
- Simultaneous events: when the ANNOUNCE collision condition and claim_ready occur in the same cycle, the collision wins and no handshake is recorded.
- Reset mid-operation returns to the reset state immediately (asynchronous), including while claim_valid is high.

Test Plan:
- No external claims, lock_req pulse, claim_ready tied 1 -> claim_id=1; board_id=8'h01 and id_locked=1 at LISTEN_CYCLES+3 cycles after lock_req; busy falls in the same cycle.
- ext_id1_claim=1 held before lock_req -> claim_id=2, board_id=8'h02; with both ext claims high -> board_id=8'h03.
- claim_ready held 0 for 20 cycles then 1 -> claim_valid and claim_id stable for all 20 cycles; board_id is updated only after the handshake.
- Board locked at ID 1, then ext_id1_claim raised for 1 cycle -> no collision. Raised for 2+ cycles -> collision pulse, id_locked=0, BACKOFF entered, then re-negotiation yields ID 2 if ext_id1_claim is still high.
- MAX_RETRY=3, ext_id1_claim toggled to force 3 collisions -> fourth SELECT picks ID 3 and locks 8'h03 regardless of occupancy.
- rst_n asserted low mid-ANNOUNCE -> claim_valid, busy, board_id and id_locked go 0 asynchronously. After release, a new lock_req completes normally, with the LFSR restarting from LFSR_SEED (backoff lengths repeat).

Source files
------------

// File: rtl/board_id_ctl.sv
// Board ID negotiation: listen for existing claims, pick the lowest free ID,
// announce it over a valid/ready link, hold it, and back off on collisions.
module board_id_ctl #(
   parameter int          LISTEN_CYCLES = 1000,
   parameter int          BACKOFF_BITS  = 8,
   parameter int          MAX_RETRY     = 3,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       lock_req,
   input  logic       ext_id1_claim,
   input  logic       ext_id2_claim,
   input  logic       claim_ready,
   output logic       claim_valid,
   output logic [1:0] claim_id,
   output logic [7:0] board_id,
   output logic       id_locked,
   output logic       busy,
   output logic       collision
);
   localparam int LW = (LISTEN_CYCLES > 2) ? $clog2(LISTEN_CYCLES) : 1;
   localparam int CW = (LW > BACKOFF_BITS + 1) ? LW : BACKOFF_BITS + 1;
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [CW-1:0] LISTEN_LOAD = CW'(LISTEN_CYCLES - 1);
   localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);

   typedef enum logic [2:0] {
      IDLE, LISTEN, SELECT, ANNOUNCE, HOLD, BACKOFF
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic [RW-1:0] retry;
   logic [15:0]   lfsr;
   logic [1:0]    sel_id, pick_id;
   logic          sync1_meta, sync1, sync2_meta, sync2;
   logic          occ1, occ2, hold_prev;
   logic          sel_claim, ann_coll, hold_coll, coll, handshake;
   logic [CW-1:0] backoff_load;

   assign sel_claim    = (sel_id == 2'd1 && sync1) || (sel_id == 2'd2 && sync2);
   assign ann_coll     = (state == ANNOUNCE) && sel_claim;
   assign hold_coll    = (state == HOLD) && sel_claim && hold_prev;
   assign coll         = ann_coll || hold_coll;
   // Link handshake: a claim transfers in the cycle where claim_valid and
   // claim_ready are both high; claim_valid/claim_id stay put until then,
   // unless a collision withdraws the claim (collision beats ready).
   assign handshake    = (state == ANNOUNCE) && !sel_claim && claim_ready;
   assign backoff_load = CW'(lfsr[BACKOFF_BITS-1:0]) + CW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_meta <= 1'b0;
         sync1      <= 1'b0;
         sync2_meta <= 1'b0;
         sync2      <= 1'b0;
      end else begin
         sync1_meta <= ext_id1_claim;
         sync1      <= sync1_meta;
         sync2_meta <= ext_id2_claim;
         sync2      <= sync2_meta;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (lock_req) state_nxt = LISTEN;
         LISTEN:   if (cnt == '0) state_nxt = SELECT;
         SELECT:   state_nxt = ANNOUNCE;
         ANNOUNCE: begin
            if (ann_coll)       state_nxt = BACKOFF;
            else if (handshake) state_nxt = HOLD;
         end
         HOLD:     if (hold_coll) state_nxt = BACKOFF;
         // The counter is loaded with at least 1, so leaving at 1 gives
         // exactly lfsr+1 backoff cycles.
         BACKOFF:  if (cnt == CW'(1)) state_nxt = LISTEN;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      pick_id = 2'd3;
      if (retry < RETRY_MAX) begin
         if (!occ1)      pick_id = 2'd1;
         else if (!occ2) pick_id = 2'd2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr      <= LFSR_SEED;
         cnt       <= '0;
         retry     <= '0;
         sel_id    <= 2'd0;
         occ1      <= 1'b0;
         occ2      <= 1'b0;
         hold_prev <= 1'b0;
      end else begin
         lfsr      <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         hold_prev <= (state == HOLD) && sel_claim;
         if (coll) begin
            cnt <= backoff_load;
            if (retry != RETRY_MAX) retry <= retry + RW'(1);
         end
         case (state)
            IDLE: begin
               if (lock_req) begin
                  cnt  <= LISTEN_LOAD;
                  occ1 <= 1'b0;
                  occ2 <= 1'b0;
               end
            end
            LISTEN: begin
               occ1 <= occ1 | sync1;
               occ2 <= occ2 | sync2;
               if (cnt != '0) cnt <= cnt - CW'(1);
            end
            SELECT: sel_id <= pick_id;
            BACKOFF: begin
               if (cnt == CW'(1)) begin
                  cnt  <= LISTEN_LOAD;
                  occ1 <= 1'b0;
                  occ2 <= 1'b0;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      claim_valid = (state == ANNOUNCE) && !sel_claim;
      claim_id    = sel_id;
      board_id    = (state == HOLD) ? {6'b0, sel_id} : 8'h00;
      id_locked   = (state == HOLD);
      busy        = (state != IDLE) && (state != HOLD);
      collision   = coll;
   end
endmodule

// File: tb/tb_board_id_ctl.sv
// Bench for board_id_ctl: directed scenarios plus randomized occupancy and
// link-ready delays, checked against a behavioural ID/backoff model.
module tb_board_id_ctl;
   localparam int          L    = 8;
   localparam int          BB   = 4;
   localparam int          MR   = 3;
   localparam logic [15:0] SEED = 16'hACE1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       lock_req = 1'b0;
   logic       ext1 = 1'b0;
   logic       ext2 = 1'b0;
   logic       claim_ready = 1'b0;
   logic       claim_valid;
   logic [1:0] claim_id;
   logic [7:0] board_id;
   logic       id_locked;
   logic       busy;
   logic       collision;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  last_id;
   logic [15:0] m_lfsr;

   always #5 clk = ~clk;

   board_id_ctl #(
      .LISTEN_CYCLES(L), .BACKOFF_BITS(BB), .MAX_RETRY(MR), .LFSR_SEED(SEED)
   ) dut (
      .clk(clk), .rst_n(rst_n), .lock_req(lock_req),
      .ext_id1_claim(ext1), .ext_id2_claim(ext2), .claim_ready(claim_ready),
      .claim_valid(claim_valid), .claim_id(claim_id), .board_id(board_id),
      .id_locked(id_locked), .busy(busy), .collision(collision)
   );

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   // Reference LFSR: seed on reset, one step per clock otherwise.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_lfsr <= SEED;
      else        m_lfsr <= lfsr_step(m_lfsr);
   end

   function automatic logic [7:0] model_id(input logic e1, input logic e2);
      if (!e1)      return 8'd1;
      else if (!e2) return 8'd2;
      else          return 8'd3;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_lock();
      lock_req = 1'b1;
      tick();
      lock_req = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      lock_req = 1'b0;
      claim_ready = 1'b0;
      ext1 = 1'b0;
      ext2 = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
   endtask

   // Full negotiation with ready held low for 'delay' ANNOUNCE cycles.
   task automatic run_lock(input int delay);
      logic [7:0] exp_id;
      exp_id = exp_q.pop_front();
      pulse_lock();
      chk("busy_after_req", busy, 1);
      repeat (L) tick();
      chk("select_no_valid", claim_valid, 0);
      tick();
      for (int d = 0; d < delay; d++) begin
         chk("wait_valid", claim_valid, 1);
         chk("wait_id", claim_id, exp_id[1:0]);
         chk("wait_no_lock", board_id, 0);
         tick();
      end
      claim_ready = 1'b1;
      chk("hs_valid", claim_valid, 1);
      chk("hs_id", claim_id, exp_id[1:0]);
      tick();
      claim_ready = 1'b0;
      chk("board_id", board_id, exp_id);
      chk("id_locked", id_locked, 1);
      chk("busy_done", busy, 0);
      chk("valid_done", claim_valid, 0);
      last_id = exp_id;
   endtask

   // Called in an ANNOUNCE cycle with ready low: force a collision on the
   // announced ID, then check the re-announce lands after the model backoff.
   task automatic announce_collide(input logic [1:0] cur_id, input logic [1:0] next_id);
      int b;
      chk("ann_valid", claim_valid, 1);
      chk("ann_id", claim_id, cur_id);
      if (cur_id == 2'd1) ext1 = 1'b1;
      else                ext2 = 1'b1;
      tick();
      chk("ann_no_coll_yet", collision, 0);
      chk("ann_still_valid", claim_valid, 1);
      tick();
      chk("ann_coll", collision, 1);
      chk("ann_withdraw", claim_valid, 0);
      b = int'(m_lfsr[BB-1:0]) + 1;
      ext1 = 1'b0;
      ext2 = 1'b0;
      repeat (b + L + 1) tick();
      chk("backoff_select", claim_valid, 0);
      tick();
      chk("reann_valid", claim_valid, 1);
      chk("reann_id", claim_id, next_id);
   endtask

   initial begin
      int b;
      logic e1, e2;
      int   dly;

      // Reset state
      tick();
      chk("rst_valid", claim_valid, 0);
      chk("rst_claim_id", claim_id, 0);
      chk("rst_board_id", board_id, 0);
      chk("rst_locked", id_locked, 0);
      chk("rst_busy", busy, 0);
      chk("rst_collision", collision, 0);

      // Free board, ready immediately: ID 1 at L+3 cycles after lock_req
      do_reset();
      exp_q.push_back(8'd1);
      run_lock(0);

      // Occupancy: ID1 taken -> 2, both taken -> 3
      do_reset();
      ext1 = 1'b1;
      repeat (3) tick();
      exp_q.push_back(model_id(1'b1, 1'b0));
      run_lock(2);
      do_reset();
      ext1 = 1'b1;
      ext2 = 1'b1;
      repeat (3) tick();
      exp_q.push_back(model_id(1'b1, 1'b1));
      run_lock(1);

      // Ready held low for 20 cycles
      do_reset();
      exp_q.push_back(8'd1);
      run_lock(20);

      // Randomized occupancy and ready delay
      for (int t = 0; t < 10; t++) begin
         do_reset();
         e1  = 1'($urandom_range(0, 1));
         e2  = 1'($urandom_range(0, 1));
         dly = int'($urandom_range(0, 6));
         ext1 = e1;
         ext2 = e2;
         repeat (3) tick();
         exp_q.push_back(model_id(e1, e2));
         run_lock(dly);
      end

      // lock_req in HOLD is ignored
      pulse_lock();
      repeat (3) tick();
      chk("hold_ignore_id", board_id, last_id);
      chk("hold_ignore_busy", busy, 0);

      // HOLD: one-cycle claim is tolerated, two cycles collide
      do_reset();
      exp_q.push_back(8'd1);
      run_lock(0);
      ext1 = 1'b1;
      tick();
      ext1 = 1'b0;
      repeat (4) begin
         tick();
         chk("glitch_no_coll", collision, 0);
         chk("glitch_locked", id_locked, 1);
      end
      ext1 = 1'b1;
      tick();
      chk("hold_pre_coll1", collision, 0);
      tick();
      chk("hold_pre_coll2", collision, 0);
      tick();
      chk("hold_coll", collision, 1);
      b = int'(m_lfsr[BB-1:0]) + 1;
      tick();
      chk("hold_coll_unlock", id_locked, 0);
      chk("hold_coll_board_id", board_id, 0);
      chk("hold_coll_busy", busy, 1);
      chk("hold_coll_pulse_end", collision, 0);
      repeat (b + L) tick();
      chk("renego_select", claim_valid, 0);
      tick();
      chk("renego_valid", claim_valid, 1);
      chk("renego_id", claim_id, 2);
      claim_ready = 1'b1;
      tick();
      claim_ready = 1'b0;
      chk("renego_board_id", board_id, 8'd2);
      chk("renego_locked", id_locked, 1);
      ext1 = 1'b0;

      // Three ANNOUNCE collisions force the spectator ID
      do_reset();
      pulse_lock();
      repeat (L + 1) tick();
      for (int k = 0; k < MR; k++) begin
         announce_collide(2'd1, (k < MR - 1) ? 2'd1 : 2'd3);
      end
      ext1 = 1'b1;
      ext2 = 1'b1;
      repeat (4) begin
         tick();
         chk("id3_no_coll", collision, 0);
         chk("id3_valid", claim_valid, 1);
         chk("id3_id", claim_id, 3);
      end
      claim_ready = 1'b1;
      tick();
      claim_ready = 1'b0;
      chk("id3_board_id", board_id, 8'd3);
      chk("id3_locked", id_locked, 1);
      ext1 = 1'b0;
      ext2 = 1'b0;

      // Asynchronous reset in the middle of ANNOUNCE
      do_reset();
      pulse_lock();
      repeat (L + 1) tick();
      chk("pre_rst_valid", claim_valid, 1);
      chk("pre_rst_busy", busy, 1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", claim_valid, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_board_id", board_id, 0);
      chk("async_rst_locked", id_locked, 0);
      @(posedge clk);
      #1;
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      chk("post_rst_idle", busy, 0);
      pulse_lock();
      repeat (L + 1) tick();
      announce_collide(2'd1, 2'd1);
      claim_ready = 1'b1;
      tick();
      claim_ready = 1'b0;
      chk("post_rst_board_id", board_id, 8'd1);
      chk("post_rst_locked", id_locked, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "bench timeout");
   end
endmodule
